// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its consumer: serial line and baud divider in,
// received word plus frame status out.
interface uart_rx_if #(
  parameter int unsigned DBITS = 3
);
  logic             rx;
  logic [15:0]      br_div;
  logic [DBITS-1:0] dout;
  logic             parity_o;
  logic             rx_done;
  logic             parity_err;
  logic             frame_err;

  modport master (
    output rx,
    output br_div,
    input  dout,
    input  parity_o,
    input  rx_done,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  br_div,
    output dout,
    output parity_o,
    output rx_done,
    output parity_err,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DBITS data bits LSB-first, one even-parity bit and
// one stop bit. Results are published together with a single-cycle rx_done pulse.
module uart_rx #(
  parameter int unsigned DBITS = 3,
  parameter int unsigned OVS   = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned BW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [TW-1:0] HalfLast = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BitLast  = TW'(OVS - 1);
  localparam logic [BW-1:0] DataLast = BW'(DBITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic rx_meta_q, rx_sync_q;

  logic [15:0] div_cnt_q, div_cnt_d;
  logic        tick_q, tick_d;

  state_e           state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             frame_end;

  logic [DBITS-1:0] dout_q;
  logic             parity_q, rx_done_q, parity_err_q, frame_err_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running oversample tick; >= keeps it alive if br_div drops below the count.
  always_comb begin
    tick_d    = 1'b0;
    div_cnt_d = div_cnt_q + 16'd1;
    if (div_cnt_q >= bus.br_div) begin
      tick_d    = 1'b1;
      div_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= 16'd0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    frame_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      StStart: begin
        if (tick_q) begin
          if (tick_cnt_q == HalfLast) begin
            // Line back high at mid start bit means a glitch, not a frame.
            state_d    = rx_sync_q ? StIdle : StData;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      StData: begin
        if (tick_q) begin
          if (tick_cnt_q == BitLast) begin
            shift_d    = {rx_sync_q, shift_q[DBITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == DataLast) begin
              state_d   = StParity;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      StParity: begin
        if (tick_q) begin
          if (tick_cnt_q == BitLast) begin
            par_bit_d  = rx_sync_q;
            state_d    = StStop;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      StStop: begin
        if (tick_q) begin
          if (tick_cnt_q == BitLast) begin
            frame_end  = 1'b1;
            state_d    = StIdle;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
    end
  end

  // Stop bit is taken straight from the line on the exiting tick; all results land together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q       <= '0;
      parity_q     <= 1'b0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q <= frame_end;
      if (frame_end) begin
        dout_q       <= shift_q;
        parity_q     <= par_bit_q;
        parity_err_q <= (^shift_q) ^ par_bit_q;
        frame_err_q  <= ~rx_sync_q;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.parity_o   = parity_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, parity and framing errors, start glitch,
// back-to-back frames at a slower baud, and reset in the middle of a frame.
module tb_uart_rx;
  localparam int unsigned DBITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DBITS(DBITS)) bus ();

  uart_rx #(.DBITS(DBITS), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [DBITS-1:0] cap_dout [0:15];
  logic             cap_perr [0:15];
  logic             cap_ferr [0:15];

  // Counts every cycle rx_done is high, so one count per frame also proves a 1-cycle pulse.
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      cap_dout[done_cnt[3:0]] <= bus.dout;
      cap_perr[done_cnt[3:0]] <= bus.parity_err;
      cap_ferr[done_cnt[3:0]] <= bus.frame_err;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DBITS-1:0] data, input logic par, input logic stop,
                            input int n);
    send_bit(1'b0, n);
    for (int i = 0; i < DBITS; i++) send_bit(data[i], n);
    send_bit(par, n);
    send_bit(stop, n);
  endtask

  task automatic check_outputs(input string tag, input int cnt, input logic [DBITS-1:0] d,
                               input logic p, input logic pe, input logic fe);
    check({tag, ".done_cnt"}, 32'(done_cnt), 32'(cnt));
    check({tag, ".dout"}, 32'(bus.dout), 32'(d));
    check({tag, ".parity_o"}, 32'(bus.parity_o), 32'(p));
    check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(pe));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
  endtask

  initial begin
    bus.rx     = 1'b1;
    bus.br_div = 16'd0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("reset.rx_done", 32'(bus.rx_done), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(3'b101, 1'b0, 1'b1, 16);
    send_bit(1'b1, 20);
    check_outputs("good_101", 1, 3'b101, 1'b0, 1'b0, 1'b0);

    send_frame(3'b001, 1'b0, 1'b1, 16);
    send_bit(1'b1, 20);
    check_outputs("perr_001", 2, 3'b001, 1'b0, 1'b1, 1'b0);

    send_frame(3'b110, 1'b0, 1'b0, 16);
    send_bit(1'b1, 40);
    check_outputs("ferr_110", 3, 3'b110, 1'b0, 1'b0, 1'b1);

    send_bit(1'b0, 4);
    send_bit(1'b1, 30);
    check_outputs("glitch", 3, 3'b110, 1'b0, 1'b0, 1'b1);

    bus.br_div = 16'd3;
    send_bit(1'b1, 16);
    send_frame(3'b011, 1'b0, 1'b1, 64);
    send_frame(3'b100, 1'b1, 1'b1, 64);
    send_bit(1'b1, 128);
    check("b2b.done_cnt", 32'(done_cnt), 32'd5);
    check("b2b.first_dout", 32'(cap_dout[3]), 32'(3'b011));
    check("b2b.first_perr", 32'(cap_perr[3]), 32'd0);
    check("b2b.first_ferr", 32'(cap_ferr[3]), 32'd0);
    check("b2b.second_dout", 32'(cap_dout[4]), 32'(3'b100));
    check("b2b.second_perr", 32'(cap_perr[4]), 32'd0);
    check_outputs("b2b.final", 5, 3'b100, 1'b1, 1'b0, 1'b0);

    // Abort a frame during its second data bit while the line is high.
    bus.br_div = 16'd0;
    send_bit(1'b1, 8);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("mid_reset", 5, 3'b000, 1'b0, 1'b0, 1'b0);
    check("mid_reset.rx_done", 32'(bus.rx_done), 32'd0);
    rst = 1'b1;
    send_bit(1'b1, 8);
    send_bit(1'b1, 48);
    send_bit(1'b1, 20);
    check_outputs("after_reset_idle", 5, 3'b000, 1'b0, 1'b0, 1'b0);

    send_frame(3'b111, 1'b1, 1'b1, 16);
    send_bit(1'b1, 20);
    check_outputs("after_reset_111", 6, 3'b111, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBITS, default 3, number of data bits per frame.
REQ-002 Parameter OVS, default 16, oversampling ticks per bit period.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 br_div  input  16  baud divider; one oversample tick every br_div+1 clk cycles.
REQ-007 dout  output  DBITS  last received data word.
REQ-008 parity_o  output  1  last received parity bit.
REQ-009 rx_done  output  1  one-cycle pulse when a frame completes.
REQ-010 parity_err  output  1  even-parity mismatch on the last frame.
REQ-011 frame_err  output  1  stop bit sampled low on the last frame.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 The tick counter SHALL count clk cycles and pulse tick for one cycle when count >= br_div, then clear; br_div=0 gives a tick every cycle; lowering br_div mid-count SHALL NOT hang.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; tick_cnt and bit_cnt are cleared on every state entry.
REQ-015 IDLE: synchronized rx=0 -> START.
REQ-016 START: on the tick with tick_cnt=OVS/2-1, rx=0 -> DATA; rx=1 -> IDLE (glitch, no rx_done); on other ticks tick_cnt increments.
REQ-017 DATA: on the tick with tick_cnt=OVS-1, the bit is shifted in LSB-first (shift_reg <= {rx, shift_reg[DBITS-1:1]}); after DBITS bits -> PARITY.
REQ-018 PARITY: on the tick with tick_cnt=OVS-1, rx is captured as the parity bit -> STOP.
REQ-019 STOP: on the tick with tick_cnt=OVS-1, rx is sampled as the stop bit -> IDLE; in the next clk cycle rx_done=1 for exactly one cycle.
REQ-020 In the rx_done cycle, dout, parity_o, parity_err (= XOR of data bits XOR parity bit) and frame_err (= NOT stop bit) SHALL update together and then hold until the next rx_done.
REQ-021 A frame with frame_err=1 SHALL still assert rx_done and update dout.
REQ-022 A new start bit SHALL be detected in IDLE in the cycle after STOP exits, so back-to-back frames are received without loss.
REQ-023 The tick counter SHALL run freely and is not resynchronized on the start edge.

Reset
REQ-024 rst low SHALL immediately force IDLE and clear tick, tick_cnt, bit_cnt and shift_reg; dout=0, parity_o=0, rx_done=0, parity_err=0 and frame_err=0.
REQ-025 Both synchronizer flops SHALL reset to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no rx_done; after release, reception resumes at the next falling edge.

Verification
REQ-027 br_div=0; frame start 0, data 3'b101 LSB-first (1,0,1), parity 0, stop 1, each bit held 16 clk -> one rx_done pulse; dout=3'b101, parity_o=0, parity_err=0, frame_err=0.
REQ-028 br_div=0; data 3'b001, parity 0, stop 1 -> dout=3'b001, parity_err=1, frame_err=0.
REQ-029 br_div=0; data 3'b110, parity 0, stop 0 -> rx_done pulses; dout=3'b110, frame_err=1, parity_err=0.
REQ-030 br_div=0; rx low for 4 clk, then high -> FSM returns to IDLE, no rx_done, outputs unchanged.
REQ-031 br_div=3 (64 clk/bit); two back-to-back frames 3'b011 then 3'b100 with correct parity -> two rx_done pulses; dout=3'b011, then 3'b100.
REQ-032 rst pulsed low during the DATA state of a frame -> no rx_done, all outputs 0; the next complete frame 3'b111 with parity 1 -> dout=3'b111, parity_err=0.
